// File: rtl/atm_auth_pkg.sv
// atm_auth_pkg - shared types and the power-on PIN table for atm_auth_engine.
// Optional lockout logic elsewhere is controlled by the ATM_LOCKOUT_EN macro.
package atm_auth_pkg;

    // Request opcodes; encodings 2 and 3 are illegal and answered with STS_BAD_OP.
    typedef enum logic [1:0] {
        OP_AUTH       = 2'd0,
        OP_CHANGE_PIN = 2'd1
    } op_e;

    // Response status codes.
    typedef enum logic [2:0] {
        STS_AUTH_OK     = 3'd0,
        STS_NOT_FOUND   = 3'd1,
        STS_BAD_PIN     = 3'd2,
        STS_LOCKED      = 3'd3,
        STS_PIN_CHANGED = 3'd4,
        STS_PIN_SAME    = 3'd5,
        STS_PIN_INVALID = 3'd6,
        STS_BAD_OP      = 3'd7
    } status_e;

    // Engine FSM states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_CHECK  = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // Power-on PIN for database entry i.
    function automatic logic [15:0] default_pin(input int i);
        case (i)
            0:       return 16'd1234;
            1:       return 16'd2345;
            2:       return 16'd3456;
            3:       return 16'd4567;
            4:       return 16'd5678;
            5:       return 16'd6789;
            6:       return 16'd7890;
            7:       return 16'd8901;
            8:       return 16'd9012;
            9:       return 16'd7123;
            default: return 16'(1000 + i);
        endcase
    endfunction

endpackage

// File: rtl/atm_fail_tracker.sv
// atm_fail_tracker - per-account consecutive-failure counters and lock flags.
// Built only when ATM_LOCKOUT_EN is defined.
`ifdef ATM_LOCKOUT_EN
module atm_fail_tracker #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 4,
    parameter int MAX_TRIES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] idx_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic [2:0]       count_o
);

    localparam logic [2:0] TRIES_V = 3'(MAX_TRIES);

    logic [2:0]              cnt_q [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q;
    logic [2:0]              cnt_inc;

    assign count_o  = cnt_q[idx_i];
    assign locked_o = lock_q[idx_i];
    assign cnt_inc  = (count_o >= TRIES_V) ? TRIES_V : count_o + 3'd1;

    // Count failures for the selected account; lock it once the limit is hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly because a reset must
            // forgive every account, so it cannot be left as uninitialised RAM.
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                cnt_q[i] <= 3'd0;
            end
            lock_q <= '0;
        end else if (inc_i) begin
            // NOTE: non-blocking so every update in this edge sees pre-edge values.
            cnt_q[idx_i] <= cnt_inc;
            if (cnt_inc == TRIES_V) begin
                lock_q[idx_i] <= 1'b1;
            end
        end else if (clr_i) begin
            cnt_q[idx_i] <= 3'd0;
        end
    end

endmodule
`endif

// File: rtl/atm_auth_engine.sv
// atm_auth_engine - sequential account/PIN authenticator with a register
// database, linear search and valid/ready request and response ports.
// Define ATM_LOCKOUT_EN to build per-account failure counting and lockout.
module atm_auth_engine
    import atm_auth_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 4,
    parameter int PIN_W        = 16,
    parameter int PIN_MAX      = 9999,
    parameter int MAX_TRIES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [ACC_W-1:0] rsp_acc_index,
    output logic [2:0]       rsp_fail_cnt
);

    localparam logic [ACC_W-1:0] LAST_IDX  = ACC_W'(NUM_ACCOUNTS - 1);
    localparam logic [PIN_W-1:0] PIN_MAX_V = PIN_W'(PIN_MAX);

    if (NUM_ACCOUNTS < 1 || NUM_ACCOUNTS > 16 || MAX_TRIES < 1 || MAX_TRIES > 7)
    begin : g_bad_params
        $error("atm_auth_engine: NUM_ACCOUNTS or MAX_TRIES out of range");
    end

    state_e           state_q, state_d;
    logic [ACC_W-1:0] idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [PIN_W-1:0] new_pin_q, new_pin_d;
    status_e          rsp_status_q, rsp_status_d;
    logic [ACC_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [2:0]       rsp_cnt_q, rsp_cnt_d;

    logic [ACC_W-1:0] acc_db_q [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_db_q [NUM_ACCOUNTS];

    logic             in_check;
    logic             pin_bad;
    logic             pin_wr;
    logic [PIN_W-1:0] cur_pin;
    status_e          chk_status;
    logic [2:0]       chk_cnt;
    logic             trk_locked;
    logic [2:0]       trk_count;
    logic [2:0]       bad_cnt;

    assign cur_pin  = pin_db_q[idx_q];
    assign in_check = (state_q == S_CHECK);
    assign pin_bad  = (pin_q != cur_pin);

`ifdef ATM_LOCKOUT_EN
    logic trk_inc;
    logic trk_clr;

    // A locked account never reaches inc/clr, so its count stays frozen.
    assign trk_inc = in_check && !trk_locked && pin_bad;
    assign trk_clr = in_check && !trk_locked && !pin_bad;
    // Unlocked implies count < MAX_TRIES, so +1 cannot pass the limit.
    assign bad_cnt = trk_count + 3'd1;

    atm_fail_tracker #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .ACC_W        (ACC_W),
        .MAX_TRIES    (MAX_TRIES)
    ) u_fail_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx_i    (idx_q),
        .inc_i    (trk_inc),
        .clr_i    (trk_clr),
        .locked_o (trk_locked),
        .count_o  (trk_count)
    );
`else
    assign trk_locked = 1'b0;
    assign trk_count  = 3'd0;
    assign bad_cnt    = 3'd0;
`endif

    // Evaluate the matched entry in priority order: lock, PIN, then the op.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        chk_status = STS_AUTH_OK;
        chk_cnt    = 3'd0;
        pin_wr     = 1'b0;
        if (trk_locked) begin
            chk_status = STS_LOCKED;
            chk_cnt    = trk_count;
        end else if (pin_bad) begin
            chk_status = STS_BAD_PIN;
            chk_cnt    = bad_cnt;
        end else if (op_q == OP_AUTH) begin
            chk_status = STS_AUTH_OK;
        end else if (new_pin_q > PIN_MAX_V) begin
            chk_status = STS_PIN_INVALID;
        end else if (new_pin_q == cur_pin) begin
            chk_status = STS_PIN_SAME;
        end else begin
            chk_status = STS_PIN_CHANGED;
            pin_wr     = in_check;
        end
    end

    // Next-state logic for the request/search/check/response sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_d         = op_q;
        acc_d        = acc_q;
        pin_d        = pin_q;
        new_pin_d    = new_pin_q;
        rsp_status_d = rsp_status_q;
        rsp_idx_d    = rsp_idx_q;
        rsp_cnt_d    = rsp_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    acc_d     = acc_num;
                    pin_d     = pin;
                    new_pin_d = new_pin;
                    idx_d     = '0;
                    if (req_op == OP_AUTH || req_op == OP_CHANGE_PIN) begin
                        state_d = S_SEARCH;
                    end else begin
                        state_d      = S_RESP;
                        rsp_status_d = STS_BAD_OP;
                        rsp_idx_d    = '0;
                        rsp_cnt_d    = 3'd0;
                    end
                end
            end
            S_SEARCH: begin
                if (acc_db_q[idx_q] == acc_q) begin
                    state_d = S_CHECK;
                end else if (idx_q == LAST_IDX) begin
                    state_d      = S_RESP;
                    rsp_status_d = STS_NOT_FOUND;
                    rsp_idx_d    = '0;
                    rsp_cnt_d    = 3'd0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d      = S_RESP;
                rsp_status_d = chk_status;
                rsp_idx_d    = idx_q;
                rsp_cnt_d    = chk_cnt;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, latched request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            op_q         <= 2'd0;
            acc_q        <= '0;
            pin_q        <= '0;
            new_pin_q    <= '0;
            rsp_status_q <= STS_AUTH_OK;
            rsp_idx_q    <= '0;
            rsp_cnt_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            pin_q        <= pin_d;
            new_pin_q    <= new_pin_d;
            rsp_status_q <= rsp_status_d;
            rsp_idx_q    <= rsp_idx_d;
            rsp_cnt_q    <= rsp_cnt_d;
        end
    end

    // Account/PIN database; only a successful PIN change in CHECK writes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                acc_db_q[i] <= ACC_W'(i + 1);
                pin_db_q[i] <= PIN_W'(default_pin(i));
            end
        end else if (pin_wr) begin
            pin_db_q[idx_q] <= new_pin_q;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_status    = rsp_status_q;
    assign rsp_acc_index = rsp_idx_q;
    assign rsp_fail_cnt  = rsp_cnt_q;

endmodule

// File: tb/tb_atm_auth_engine.sv
// tb_atm_auth_engine - directed and randomized checks of atm_auth_engine
// against a table-level reference model. Honors ATM_LOCKOUT_EN.
module tb_atm_auth_engine;

    localparam int N_ACC     = 10;
    localparam int MAX_TRIES = 3;
`ifdef ATM_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [3:0]  rsp_acc_index;
    logic [2:0]  rsp_fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: account i+1 lives at index i.
    int m_pin  [N_ACC];
    int m_cnt  [N_ACC];
    bit m_lock [N_ACC];
    int def_pins [N_ACC] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};

    atm_auth_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .acc_num       (acc_num),
        .pin           (pin),
        .new_pin       (new_pin),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .rsp_acc_index (rsp_acc_index),
        .rsp_fail_cnt  (rsp_fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_ACC; i++) begin
            m_pin[i]  = def_pins[i];
            m_cnt[i]  = 0;
            m_lock[i] = 1'b0;
        end
    endtask

    task automatic scramble(input bit with_valid);
        req_valid = with_valid ? 1'($urandom) : 1'b0;
        req_op    = 2'($urandom);
        acc_num   = 4'($urandom);
        pin       = 16'($urandom);
        new_pin   = 16'($urandom);
    endtask

    // One complete request/response exchange, response held for 'hold' cycles.
    task automatic send(input int op, input int acc, input int p, input int np, input int hold);
        int exp_status, exp_idx, exp_cnt, exp_lat, k, lat;
        k = -1;
        for (int i = 0; i < N_ACC; i++) begin
            if (k < 0 && acc == i + 1) k = i;
        end
        exp_idx = 0;
        exp_cnt = 0;
        exp_lat = 0;
        if (op > 1) begin
            exp_status = 7;
        end else if (k < 0) begin
            exp_status = 1;
            exp_lat    = N_ACC;
        end else begin
            exp_idx = k;
            exp_lat = k + 2;
            if (LOCKOUT && m_lock[k]) begin
                exp_status = 3;
                exp_cnt    = m_cnt[k];
            end else if (p != m_pin[k]) begin
                exp_status = 2;
                if (LOCKOUT) begin
                    if (m_cnt[k] < MAX_TRIES) m_cnt[k]++;
                    if (m_cnt[k] == MAX_TRIES) m_lock[k] = 1'b1;
                    exp_cnt = m_cnt[k];
                end
            end else begin
                m_cnt[k] = 0;
                if (op == 0)                exp_status = 0;
                else if (np > 9999)         exp_status = 6;
                else if (np == m_pin[k])    exp_status = 5;
                else begin
                    m_pin[k]   = np;
                    exp_status = 4;
                end
            end
        end

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 2'(op);
        acc_num   = 4'(acc);
        pin       = 16'(p);
        new_pin   = 16'(np);
        rsp_ready = (hold == 0);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        scramble(1'b0);
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            scramble(1'b0);
        end
        if (op > 1) check("bad_op_latency_le1", 32'(lat <= 1), 32'd1);
        else        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_status", 32'(rsp_status), 32'(exp_status));
        check("rsp_acc_index", 32'(rsp_acc_index), 32'(exp_idx));
        check("rsp_fail_cnt", 32'(rsp_fail_cnt), 32'(exp_cnt));

        for (int c = 0; c < hold; c++) begin
            scramble(1'b1);
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_status", 32'(rsp_status), 32'(exp_status));
            check("hold_index", 32'(rsp_acc_index), 32'(exp_idx));
            check("hold_fail_cnt", 32'(rsp_fail_cnt), 32'(exp_cnt));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("consumed_rsp_valid", 32'(rsp_valid), 32'd0);
        check("consumed_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int r_op, r_acc, r_pin, r_np, sel;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        acc_num   = 4'd0;
        pin       = 16'd0;
        new_pin   = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_status", 32'(rsp_status), 32'd0);
        check("reset_rsp_index", 32'(rsp_acc_index), 32'd0);
        check("reset_rsp_fail_cnt", 32'(rsp_fail_cnt), 32'd0);

        // Basic AUTH and not-found cases.
        send(0, 3, 3456, 0, 0);
        send(0, 12, 1234, 0, 0);
        send(0, 0, 1234, 0, 0);

        // Repeated bad PINs, then the correct PIN.
        send(0, 1, 0, 0, 0);
        send(0, 1, 0, 0, 0);
        send(0, 1, 0, 0, 0);
        send(0, 1, 1234, 0, 0);

        // PIN change rules.
        send(1, 5, 5678, 5678, 0);
        send(1, 5, 5678, 10000, 0);
        send(1, 5, 5678, 4321, 0);
        send(0, 5, 4321, 0, 0);
        send(0, 5, 5678, 0, 0);

        // Backpressure with input churn.
        send(3, 7, 7890, 0, 5);
        send(0, 9, 9012, 0, 5);
        send(2, 10, 7123, 0, 2);

        // Reset during SEARCH after a PIN change.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        acc_num   = 4'd10;
        pin       = 16'd7123;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("search_req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        check("midreset_rsp_status", 32'(rsp_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send(0, 5, 5678, 0, 0);
        send(0, 1, 0, 0, 0);
        send(0, 1, 1234, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            r_op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
            r_acc = int'($urandom_range(0, 15));
            if (r_acc >= 1 && r_acc <= N_ACC && $urandom_range(0, 3) != 0)
                r_pin = m_pin[r_acc - 1];
            else
                r_pin = int'($urandom_range(0, 9999));
            sel = int'($urandom_range(0, 3));
            if (sel == 0 && r_acc >= 1 && r_acc <= N_ACC) r_np = m_pin[r_acc - 1];
            else if (sel == 1)                            r_np = int'($urandom_range(10000, 65535));
            else                                          r_np = int'($urandom_range(0, 9999));
            send(r_op, r_acc, r_pin, r_np, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_auth_engine.md
Name: atm_auth_engine

Overview:
- Sequential, parametrised successor to the combinational account authenticator.
- Holds the account/PIN database in registers and serves AUTH and CHANGE_PIN requests over a valid/ready request port and a valid/ready response port.
- Searches the database one entry per cycle and tracks failed attempts per account, locking an account after too many failures.
- Sits between the ATM control FSM and the transaction datapath.

Parameters:
- NUM_ACCOUNTS, 10, number of database entries (1..16).
- ACC_W, 4, account number width.
- PIN_W, 16, PIN width.
- PIN_MAX, 9999, largest legal PIN value (4 decimal digits).
- MAX_TRIES, 3, consecutive failures that lock an account (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_op  in  2  0=AUTH, 1=CHANGE_PIN, others illegal.
- acc_num  in  ACC_W  account number.
- pin  in  PIN_W  current PIN.
- new_pin  in  PIN_W  replacement PIN (CHANGE_PIN only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_status  out  3  result code (see Behaviour).
- rsp_acc_index  out  ACC_W  matched database index; 0 when not found.
- rsp_fail_cnt  out  3  account failure count after this request.

Behaviour:
- Reset values:
  - req_ready=1; rsp_valid=0; rsp_status=0; rsp_acc_index=0; rsp_fail_cnt=0.
  - FSM=IDLE; all failure counters=0; all lock flags=0.
  - Entry i: acc_num_db = i+1.
  - Entry i, i<10: pin_db = 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123.
  - Entry i, i>=10: pin_db = 1000+i.
- Status codes:
  - 0 AUTH_OK, 1 NOT_FOUND, 2 BAD_PIN, 3 LOCKED.
  - 4 PIN_CHANGED, 5 PIN_SAME, 6 PIN_INVALID, 7 BAD_OP.
- Handshake:
  - req_ready=1 only in IDLE. A transfer is req_valid && req_ready.
  - On transfer, op, acc_num, pin and new_pin are latched; later input changes are ignored.
  - rsp_valid and all rsp_* fields stay stable until rsp_valid && rsp_ready.
- FSM states: IDLE, SEARCH, CHECK, RESP.
  - IDLE -> SEARCH on transfer; idx=0. An illegal op goes IDLE -> RESP with BAD_OP and touches no state.
  - SEARCH compares entry idx each cycle:
    - match -> CHECK, idx held;
    - no match and idx==NUM_ACCOUNTS-1 -> RESP with NOT_FOUND;
    - otherwise idx+1.
  - CHECK is one cycle, evaluated in priority order:
    1. Locked -> LOCKED; counter unchanged.
    2. pin != pin_db -> BAD_PIN; counter +1, saturating at MAX_TRIES; lock set when it reaches MAX_TRIES.
    3. AUTH -> AUTH_OK; counter cleared.
    4. CHANGE_PIN with new_pin > PIN_MAX -> PIN_INVALID; counter cleared.
    5. CHANGE_PIN with new_pin == pin_db -> PIN_SAME; counter cleared.
    6. Otherwise pin_db <= new_pin -> PIN_CHANGED; counter cleared.
    Then -> RESP.
  - RESP -> IDLE on rsp_ready. rsp_ready high on the first RESP cycle gives a one-cycle response.
- Latency:
  - Match at index k: rsp_valid rises k+2 cycles after the accepting edge.
  - NOT_FOUND: NUM_ACCOUNTS cycles.
  - BAD_OP: 1 cycle.
- Database writes happen only in CHECK. A PIN written by PIN_CHANGED is visible to the next request.
- Duplicate acc_num entries: the lowest index wins.
- acc_num=0 or any value above the table is NOT_FOUND.
- Reset mid-operation: FSM returns to IDLE immediately; the database and counters return to reset values; any pending response is dropped.

Optional Feature:
- Macro: ATM_LOCKOUT_EN.
- Defined: failure counters and lock flags exist as described.
- Undefined:
  - No counters or lock flags are built.
  - LOCKED is never returned; BAD_PIN changes no state.
  - rsp_fail_cnt is tied to 0.
  - Status encoding is unchanged.

Decomposition:
- Package atm_auth_pkg holds:
  - op enum (OP_AUTH, OP_CHANGE_PIN);
  - status enum (8 codes above);
  - FSM state enum;
  - the default PIN table and function default_pin(i).
- One sub-module, atm_fail_tracker:
  - holds the per-account failure counters and lock flags;
  - takes idx, inc and clr inputs; returns locked and count outputs;
  - compiled only under ATM_LOCKOUT_EN.

Test Plan:
- After reset, AUTH acc 3 pin 3456, rsp_ready=1 -> AUTH_OK, index 2, rsp_valid 4 cycles after accept.
- AUTH acc 12 -> NOT_FOUND after 10 cycles; acc 0 -> NOT_FOUND.
- AUTH acc 1 pin 0000 three times -> BAD_PIN with fail_cnt 1, 2, 3. Then AUTH acc 1 pin 1234 -> LOCKED. Without ATM_LOCKOUT_EN the fourth request gives AUTH_OK.
- CHANGE_PIN acc 5 pin 5678:
  - new_pin 5678 -> PIN_SAME;
  - new_pin 10000 -> PIN_INVALID;
  - new_pin 4321 -> PIN_CHANGED, then AUTH pin 4321 -> AUTH_OK and AUTH pin 5678 -> BAD_PIN.
- Backpressure: hold rsp_ready=0 for 5 cycles while toggling all request inputs -> rsp fields stable, req_ready=0; op=3 -> BAD_OP.
- Assert rst_n low during SEARCH after a prior PIN change -> rsp_valid=0, req_ready=1, PIN restored to default and counters 0.
